// File: rtl/bus_arbiter2_pkg.sv
// Shared types and constants for the two-master PicoRV32 bus arbiter.
// Optional feature macro: BUS_ARBITER2_ROUND_ROBIN_EN (see bus_arbiter2.sv).
package bus_arbiter2_pkg;

  // Arbiter phase: IDLE arbitrates, BUSY owns the slave for one transaction.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Read data returned to a master whose access was killed by the watchdog.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Widest address carried by the request struct; ADDR_WIDTH must not exceed it.
  localparam int ADDR_MAX_W = 32;

  // One master's request fields as presented to the slave.
  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } bus_req_t;

  // Pick a master from two request lines. A lone requester always wins;
  // under contention prefer_m1 decides.
  function automatic logic pick_master(input logic v0, input logic v1,
                                       input logic prefer_m1);
    if (v0 && v1) return prefer_m1;
    return v1;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating wait counter for the bus arbiter: counts stalled slave cycles
// and flags when the count has reached TIMEOUT. Never wraps.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LP_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Clear while idle, count stalled cycles while busy, hold at the limit.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LP_LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master arbiter for the PicoRV32 native memory bus. Master 0 (CPU) and
// master 1 (DMA / debug loader) share one slave port, one transaction at a
// time, with a watchdog that terminates slave accesses that never complete.
//
// Macro BUS_ARBITER2_ROUND_ROBIN_EN:
//   defined   - contention alternates using a last-grant pointer.
//   undefined - fixed priority, master 0 always wins contention.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  s_valid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic                  s_ready,
  input  logic [31:0]           s_rdata,
  output logic                  timeout
);

  state_e   r_state;
  logic     r_owner;

  bus_req_t w_req0;
  bus_req_t w_req1;
  bus_req_t w_own_req;
  logic     w_own_valid;
  logic     w_busy;
  logic     w_s_active;
  logic     w_done;
  logic     w_expired;
  logic     w_tmo;
  logic     w_finish;
  logic     w_any_req;
  logic     w_prefer_m1;
  logic     w_grant;
  logic [31:0] w_rdata;

  assign w_req0 = '{addr: ADDR_MAX_W'(m0_addr), wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_req1 = '{addr: ADDR_MAX_W'(m1_addr), wdata: m1_wdata, wstrb: m1_wstrb};

  assign w_own_req   = r_owner ? w_req1 : w_req0;
  assign w_own_valid = r_owner ? m1_valid : m0_valid;
  assign w_busy      = (r_state == ST_BUSY);

  // The slave sees the owner's request only while BUSY and the owner holds valid.
  assign w_s_active  = w_busy && w_own_valid;
  assign w_done      = w_s_active && s_ready;
  // A late s_ready in the expiry cycle is a normal completion, not a timeout.
  assign w_tmo       = w_s_active && !s_ready && w_expired;
  assign w_finish    = w_done || w_tmo;
  assign w_rdata     = w_done ? s_rdata : TIMEOUT_RDATA;

  // ---------------- arbitration ----------------
  assign w_any_req = m0_valid || m1_valid;

`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
  logic r_last;
  // Under contention, prefer whichever master was not granted last.
  assign w_prefer_m1 = !r_last;
`else
  // Fixed priority: master 1 only wins when master 0 is not requesting.
  assign w_prefer_m1 = 1'b0;
`endif

  assign w_grant = pick_master(m0_valid, m1_valid, w_prefer_m1);

  // Arbitration FSM: grant in IDLE, hold ownership in BUSY until the
  // transaction completes, times out, or the owner withdraws its request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else if (r_state == ST_IDLE) begin
      if (w_any_req) begin
        r_owner <= w_grant;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
        r_last  <= w_grant;
`endif
        r_state <= ST_BUSY;
      end
    end else begin
      if (!w_own_valid || w_finish) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // ---------------- watchdog ----------------
  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_busy),
    .i_enable  (w_s_active && !s_ready),
    .o_expired (w_expired)
  );

  // ---------------- outputs ----------------
  assign s_valid  = w_s_active;
  assign s_addr   = w_busy ? w_own_req.addr[ADDR_WIDTH-1:0] : '0;
  assign s_wdata  = w_busy ? w_own_req.wdata : '0;
  assign s_wstrb  = w_busy ? w_own_req.wstrb : '0;

  assign m0_ready = w_finish && !r_owner;
  assign m1_ready = w_finish &&  r_owner;
  assign m0_rdata = m0_ready ? w_rdata : '0;
  assign m1_rdata = m1_ready ? w_rdata : '0;
  assign timeout  = w_tmo;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2 (TIMEOUT = 4). Directed scenarios plus
// randomized traffic, all compared each cycle against a transaction-level
// reference model of the arbitration rules.
module tb_bus_arbiter2;
  import bus_arbiter2_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_ready;
  logic [31:0]   s_rdata;
  logic          timeout;

  always #5 clock = ~clock;

  bus_arbiter2 #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .m0_valid (m0_valid),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (m1_valid),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .timeout  (timeout)
  );

  typedef struct packed {
    logic          m0_ready;
    logic          m1_ready;
    logic [31:0]   m0_rdata;
    logic [31:0]   m1_rdata;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          timeout;
  } out_t;

  out_t g_obs, g_exp;
  int   g_checks = 0;
  int   g_errors = 0;
  int   g_cycle  = 0;

  // Reference model: which master holds the bus, who won last, and how many
  // stalled slave cycles the current transaction has seen.
  bit md_busy  = 1'b0;
  bit md_owner = 1'b0;
  bit md_last  = 1'b1;
  int md_wait  = 0;

  function automatic out_t dut_out();
    out_t o;
    o.m0_ready = m0_ready;
    o.m1_ready = m1_ready;
    o.m0_rdata = m0_rdata;
    o.m1_rdata = m1_rdata;
    o.s_valid  = s_valid;
    o.s_addr   = s_addr;
    o.s_wdata  = s_wdata;
    o.s_wstrb  = s_wstrb;
    o.timeout  = timeout;
    return o;
  endfunction

  // Expected outputs for the current cycle from model state and current inputs.
  function automatic out_t model_out();
    out_t        e = '0;
    bit          ov, done, tmo;
    logic [31:0] rd;
    if (!md_busy) return e;
    ov        = md_owner ? m1_valid : m0_valid;
    e.s_valid = ov;
    e.s_addr  = md_owner ? m1_addr  : m0_addr;
    e.s_wdata = md_owner ? m1_wdata : m0_wdata;
    e.s_wstrb = md_owner ? m1_wstrb : m0_wstrb;
    done      = ov && s_ready;
    tmo       = ov && !s_ready && (md_wait == TMO);
    e.timeout = tmo;
    if (done || tmo) begin
      rd = done ? s_rdata : 32'hDEAD_BEEF;
      if (md_owner) begin e.m1_ready = 1'b1; e.m1_rdata = rd; end
      else          begin e.m0_ready = 1'b1; e.m0_rdata = rd; end
    end
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs seen this cycle.
  function automatic void model_step();
    bit ov;
    if (reset) begin
      md_busy = 1'b0; md_owner = 1'b0; md_last = 1'b1; md_wait = 0;
      return;
    end
    if (!md_busy) begin
      if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) begin
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
          md_owner = !md_last;
`else
          md_owner = 1'b0;
`endif
        end else begin
          md_owner = m1_valid;
        end
        md_last = md_owner;
        md_wait = 0;
        md_busy = 1'b1;
      end
    end else begin
      ov = md_owner ? m1_valid : m0_valid;
      if (!ov || s_ready || (md_wait == TMO)) md_busy = 1'b0;
      else                                    md_wait++;
    end
  endfunction

  // Sample DUT and model mid-cycle, away from the active edge.
  task automatic settle();
    @(negedge clock);
    g_obs = dut_out();
    g_exp = model_out();
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
    g_cycle++;
  endtask

  task automatic idle_cycles(input int n);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    repeat (n) advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    advance();
    advance();
    settle();
    g_checks++;
    if (g_obs !== out_t'(0)) begin
      g_errors++;
      $display("FAIL reset_outputs cyc=%0d got=%h exp=0", g_cycle, g_obs);
    end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_single_write();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF;
    s_ready = 1'b1; s_rdata = 32'hA5A5_0001;
    settle();
    g_checks++;
    if (g_obs !== g_exp) begin
      g_errors++;
      $display("FAIL single_grant_cycle cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
    end
    advance();
    settle();
    g_checks++;
    if ({g_obs.s_valid, g_obs.s_addr, g_obs.s_wdata, g_obs.s_wstrb} !==
        {1'b1, 32'h100, 32'h1234_5678, 4'hF}) begin
      g_errors++;
      $display("FAIL single_slave_fields cyc=%0d got=%b/%h/%h/%h exp=1/100/12345678/f",
               g_cycle, g_obs.s_valid, g_obs.s_addr, g_obs.s_wdata, g_obs.s_wstrb);
    end
    g_checks++;
    if ({g_obs.m0_ready, g_obs.m1_ready, g_obs.m0_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
      g_errors++;
      $display("FAIL single_ready cyc=%0d got=%b/%b/%h exp=1/0/a5a50001",
               g_cycle, g_obs.m0_ready, g_obs.m1_ready, g_obs.m0_rdata);
    end
    advance();
    m0_valid = 1'b0;
    settle();
    g_checks++;
    if (g_obs !== g_exp) begin
      g_errors++;
      $display("FAIL single_after cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
    end
    idle_cycles(2);
  endtask

  task automatic test_contention();
    int grants[$];
    int gcyc[$];
    int want;
    bit found;
    m0_valid = 1'b1; m0_addr = 32'h1000; m0_wdata = 32'h0000_1111; m0_wstrb = 4'h3;
    m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h0000_2222; m1_wstrb = 4'h0;
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    for (int c = 0; c < 20 && grants.size() < 4; c++) begin
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL contention_cycle cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      if (g_obs.s_valid) begin
        grants.push_back((g_obs.s_addr == 32'h2000) ? 1 : 0);
        gcyc.push_back(c);
      end
      advance();
    end
    g_checks++;
    if (grants.size() != 4) begin
      g_errors++;
      $display("FAIL contention_count got=%0d exp=4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
        want = i % 2;
`else
        want = 0;
`endif
        g_checks++;
        if (grants[i] != want) begin
          g_errors++;
          $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, grants[i], want);
        end
        if (i > 0) begin
          g_checks++;
          if (gcyc[i] - gcyc[i-1] != 2) begin
            g_errors++;
            $display("FAIL contention_gap idx=%0d got=%0d exp=2", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    // Releasing master 0 must let master 1 through.
    m0_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      settle();
      if (g_obs.s_valid && g_obs.s_addr == 32'h2000) found = 1'b1;
      advance();
    end
    g_checks++;
    if (!found) begin
      g_errors++;
      $display("FAIL contention_release got=no_m1_grant exp=m1_grant");
    end
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    int  sv_cycles = 0;
    int  tmo_pulses = 0;
    int  sv_at_ready = -1;
    logic [31:0] rd = '0;
    bit  done = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h300; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 20 && !done; c++) begin
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL timeout_cycle cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      if (g_obs.s_valid) sv_cycles++;
      if (g_obs.timeout) tmo_pulses++;
      if (g_obs.m0_ready) begin sv_at_ready = sv_cycles; rd = g_obs.m0_rdata; done = 1'b1; end
      advance();
    end
    m0_valid = 1'b0;
    settle();
    if (g_obs.timeout) tmo_pulses++;
    advance();
    g_checks++;
    if (sv_at_ready != TMO + 1) begin
      g_errors++;
      $display("FAIL timeout_latency got=%0d exp=%0d", sv_at_ready, TMO + 1);
    end
    g_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      g_errors++;
      $display("FAIL timeout_rdata got=%h exp=deadbeef", rd);
    end
    g_checks++;
    if (tmo_pulses != 1) begin
      g_errors++;
      $display("FAIL timeout_pulses got=%0d exp=1", tmo_pulses);
    end
    idle_cycles(2);
  endtask

  task automatic test_late_ready();
    int  sv_cycles = 0;
    int  tmo_pulses = 0;
    bit  done = 1'b0;
    logic [31:0] rd = '0;
    m0_valid = 1'b1; m0_addr = 32'h304; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (sv_cycles == TMO) begin s_ready = 1'b1; s_rdata = 32'hCAFE_F00D; end
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL late_cycle cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      if (g_obs.s_valid) sv_cycles++;
      if (g_obs.timeout) tmo_pulses++;
      if (g_obs.m0_ready) begin rd = g_obs.m0_rdata; done = 1'b1; end
      advance();
    end
    g_checks++;
    if (!done || rd !== 32'hCAFE_F00D || tmo_pulses != 0) begin
      g_errors++;
      $display("FAIL late_ready got=done%0d/%h/tmo%0d exp=done1/cafef00d/tmo0",
               done, rd, tmo_pulses);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_midstall();
    m0_valid = 1'b1; m0_addr = 32'h400; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0;
    repeat (3) advance();
    reset = 1'b1;
    settle();
    g_checks++;
    if (g_obs !== g_exp) begin
      g_errors++;
      $display("FAIL midreset_before cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
    end
    advance();
    settle();
    g_checks++;
    if (g_obs !== out_t'(0)) begin
      g_errors++;
      $display("FAIL midreset_outputs cyc=%0d got=%h exp=0", g_cycle, g_obs);
    end
    reset = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h500; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    advance();
    settle();
    g_checks++;
    if (g_obs.s_valid !== 1'b1 || g_obs.s_addr !== 32'h400) begin
      g_errors++;
      $display("FAIL midreset_first_grant got=%b/%h exp=1/400", g_obs.s_valid, g_obs.s_addr);
    end
    idle_cycles(2);
  endtask

  task automatic test_drop_valid();
    m1_valid = 1'b1; m1_addr = 32'h600; m1_wdata = 32'h77; m1_wstrb = 4'h1;
    s_ready = 1'b0;
    repeat (3) begin
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL drop_stall cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      advance();
    end
    m1_valid = 1'b0;
    repeat (2) begin
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL drop_abandon cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      advance();
    end
  endtask

  task automatic test_random();
    int  stall_left = 0;
    bit  r0, r1;
    for (int c = 0; c < 600; c++) begin
      if (!m0_valid && $urandom_range(0, 1) == 1) begin
        m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (!m1_valid && $urandom_range(0, 1) == 1) begin
        m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
      if (stall_left == 0 && $urandom_range(0, 15) == 0) stall_left = $urandom_range(3, 8);
      if (stall_left > 0) begin s_ready = 1'b0; stall_left--; end
      else                s_ready = ($urandom_range(0, 3) != 0);
      s_rdata = $urandom;
      settle();
      g_checks++;
      if (g_obs !== g_exp) begin
        g_errors++;
        $display("FAIL random_cycle cyc=%0d got=%h exp=%h", g_cycle, g_obs, g_exp);
      end
      r0 = g_exp.m0_ready;
      r1 = g_exp.m1_ready;
      advance();
      if (r0) m0_valid = 1'b0;
      if (r1) m1_valid = 1'b0;
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_timeout();
    test_late_ready();
    test_reset_midstall();
    test_drop_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", g_checks, g_errors);
    $finish;
  end

endmodule
